// File: rtl/show_digital.sv
// show_digital: 1101 serial sequence detector with 4-digit multiplexed 7-segment readout (optional MATCH_COUNT_EN adds BCD match counter on digits 3,2)
module show_digital #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       res_en,
    output logic [3:0] sel,
    output logic [7:0] data
);
    typedef enum logic [1:0] {S0, S1, S11, S110} state_t;
    localparam int CW = $clog2(SCAN_DIV);
    logic          key_s1, key_s2;
    logic          en_s1, en_s2, en_s3;
    logic          sample_pulse;
    state_t        state, state_nxt;
    logic          hit;
    logic          match;
    logic [3:0]    hist;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    dig_val;
    logic [3:0]    sel_nxt;
    logic [7:0]    data_nxt;
`ifdef MATCH_COUNT_EN
    logic [3:0]    tens, units;
`endif

    assign sample_pulse = en_s2 & ~en_s3;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Synchronize key/res_en into clk domain; third res_en flop feeds the edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            en_s3  <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            en_s1  <= res_en;
            en_s2  <= en_s1;
            en_s3  <= en_s2;
        end
    end

    // Mealy next state; a hit is a 1 arriving while in S110
    always_comb begin
        hit       = (state == S110) && key_s2;
        state_nxt = S0;
        case (state)
            S0:      state_nxt = key_s2 ? S1  : S0;
            S1:      state_nxt = key_s2 ? S11 : S0;
            S11:     state_nxt = key_s2 ? S11 : S110;
            default: state_nxt = key_s2 ? S1  : S0;
        endcase
    end

    // FSM, history and match flag all advance only on a sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
            hist  <= 4'b0;
            match <= 1'b0;
        end else if (sample_pulse) begin
            state <= state_nxt;
            hist  <= {hist[2:0], key_s2};
            match <= hit;
        end
    end

`ifdef MATCH_COUNT_EN
    // Two-digit BCD match counter wrapping 99 -> 00
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (sample_pulse && hit) begin
            units <= (units == 4'd9) ? 4'd0 : units + 4'd1;
            if (units == 4'd9)
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end
    end
`endif

    // Scan timer: digit index advances each time the divider wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Select and segment pattern for the current digit, computed together
    always_comb begin
        dig_val = {3'b000, hist[idx]};
`ifdef MATCH_COUNT_EN
        dig_val = (idx == 2'd3) ? tens : (idx == 2'd2) ? units : dig_val;
`endif
        sel_nxt  = ~(4'b0001 << idx);
        data_nxt = {~((idx == 2'd0) && match), seg(dig_val)};
    end

    // Register sel and data in the same flop stage so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 4'b1110;
            data <= 8'hC0;
        end else begin
            sel  <= sel_nxt;
            data <= data_nxt;
        end
    end
endmodule

// File: tb/tb_show_digital.sv
// tb_show_digital: directed self-checking bench for show_digital (default build, SCAN_DIV=4)
module tb_show_digital;
    logic       clk;
    logic       rst_n;
    logic       key;
    logic       res_en;
    logic [3:0] sel;
    logic [7:0] data;
    int         checks;
    int         failures;
    logic [31:0] frame;

    show_digital #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key),
        .res_en (res_en),
        .sel    (sel),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Collect one full scan of the four digits, packed {d3,d2,d1,d0}
    task automatic read_frame(output logic [31:0] f);
        f = 32'h0;
        repeat (16) begin
            @(negedge clk);
            case (sel)
                4'b1110: f[7:0]   = data;
                4'b1101: f[15:8]  = data;
                4'b1011: f[23:16] = data;
                4'b0111: f[31:24] = data;
                default: ;
            endcase
        end
    endtask

    task automatic do_sample(input logic b, input logic [31:0] exp, input string tag);
        logic [31:0] f;
        @(negedge clk);
        key = b;
        repeat (2) @(negedge clk);
        res_en = 1'b1;
        repeat (4) @(negedge clk);
        res_en = 1'b0;
        repeat (4) @(negedge clk);
        read_frame(f);
        check(tag, f, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] prev;
        int         start;
        int         n;
        int         di;
        checks   = 0;
        failures = 0;
        key      = 1'b0;
        res_en   = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_sel", {28'b0, sel}, 32'hE);
        check("rst_data", {24'b0, data}, 32'hC0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_frame(frame);
        check("idle_frame", frame, 32'hC0C0C0C0);

        do_sample(1'b1, 32'hC0C0C0F9, "s1_1");
        do_sample(1'b1, 32'hC0C0F9F9, "s1_2");
        do_sample(1'b0, 32'hC0F9F9C0, "s1_3");
        do_sample(1'b1, 32'hF9F9C079, "s1_4_match");

        @(negedge clk);
        key = 1'b0;
        repeat (2) @(negedge clk);
        res_en = 1'b1;
        repeat (50) @(negedge clk);
        read_frame(frame);
        check("hold_high", frame, 32'hF9C0F9C0);
        res_en = 1'b0;
        repeat (4) @(negedge clk);
        read_frame(frame);
        check("hold_low", frame, 32'hF9C0F9C0);

        do_sample(1'b1, 32'hC0F9C0F9, "pre_1");
        do_sample(1'b1, 32'hF9C0F9F9, "pre_2");
        do_sample(1'b0, 32'hC0F9F9C0, "pre_3");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_sel", {28'b0, sel}, 32'hE);
        check("async_data", {24'b0, data}, 32'hC0);
        @(negedge clk);
        rst_n = 1'b1;
        read_frame(frame);
        check("async_frame", frame, 32'hC0C0C0C0);
        do_sample(1'b1, 32'hC0C0C0F9, "async_fsm_clear");

        pulse_reset();
        do_sample(1'b1, 32'hC0C0C0F9, "ov_1");
        do_sample(1'b1, 32'hC0C0F9F9, "ov_2");
        do_sample(1'b0, 32'hC0F9F9C0, "ov_3");
        do_sample(1'b1, 32'hF9F9C079, "ov_4_match");
        do_sample(1'b1, 32'hF9C0F9F9, "ov_5_nomatch");
        do_sample(1'b0, 32'hC0F9F9C0, "ov_6_nomatch");
        do_sample(1'b1, 32'hF9F9C079, "ov_7_match");

        frame = 32'hF9F9C079;
        @(negedge clk);
        prev = sel;
        n = 0;
        while (sel == prev && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scan_sync", {31'b0, sel != prev}, 32'h1);
        start = (sel == 4'b1101) ? 1 : (sel == 4'b1011) ? 2 : (sel == 4'b0111) ? 3 : 0;
        for (int k = 0; k < 32; k++) begin
            di = (start + k / 4) % 4;
            check("scan_sel", {28'b0, sel}, {28'b0, ~(4'b0001 << di)});
            check("scan_data", {24'b0, data}, (frame >> (8 * di)) & 32'hFF);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
